seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle restoring divider that inverts the 2x3 multiplier: it takes a 5-bit product-width dividend and a 2-bit divisor and returns quotient and remainder, one quotient bit per clock. It sits beside the multiplier in the FPGA arithmetic project. Multiplier and divider are verified together by round-trip checks (dividend = divisor*quotient + remainder). Control is a start/busy/done handshake so a sequencer or testbench can drive it.

## Interface

Parameters:
- DW, 5: dividend and quotient width.
- VW, 2: divisor and remainder width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- dividend  in  DW  numerator; latched on accepted start.
- divisor  in  VW  denominator; latched on accepted start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  DW  result quotient; held until next accepted start.
- remainder  out  VW  result remainder; held until next accepted start.
- div_by_zero  out  1  set with done when divisor was 0; held with results.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches operands, clears the iteration counter, goes to RUN. If the latched divisor is 0, goes to DONE instead.
  - RUN: one restoring step per cycle, MSB of dividend first. Exits to DONE after DW steps.
  - DONE: done=1 for exactly this cycle, then IDLE. start=1 in DONE is accepted exactly as in IDLE; done still pulses this cycle.
- Restoring step:
  - partial remainder register is VW+1 bits: pr = {pr[VW-1:0], next dividend bit}.
  - if pr >= divisor then pr = pr - divisor and q bit = 1, else q bit = 0.
  - Shift-register implementation of dividend/quotient is free; the iteration counter is ceil(log2(DW+1)) bits.
- Results: quotient = floor(dividend/divisor) and remainder = dividend mod divisor, both unsigned. quotient/remainder/div_by_zero update only on entry to DONE.
- Divide by zero: quotient = all ones (31 at DW=5), remainder = 0, div_by_zero = 1.
- Any non-zero result or div_by_zero is cleared only by the next accepted start or by reset.
- start while in RUN is ignored. Operand inputs are don't-care except in the accepted-start cycle.
- Reset, asynchronous and effective at any time including mid-RUN: FSM=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers 0. The in-flight division is discarded with no done pulse.

## Timing

- Accepted start at edge k:
  - busy=1 from after edge k.
  - steps at edges k+1 .. k+DW.
  - done=1, results valid after edge k+DW (start edge included: DW+1 cycles latency, 6 at default).
  - busy=0 in the DONE cycle.
- Divide by zero: done=1 after edge k, i.e. 1-cycle latency.
- busy is 1 exactly in RUN. done is 1 exactly in DONE.
- Back-to-back: start held high gives one result every DW+1 cycles. done pulses each time, and busy drops for only the DONE cycle.
- No combinational path from inputs to outputs.

## Test plan

- 21 / 3, start pulsed one cycle:
  - busy=1 for 5 cycles, then done=1 for one cycle with quotient=7, remainder=0, div_by_zero=0.
  - outputs still 7/0 ten cycles later.
- 23 / 2 gives quotient=11, remainder=1. 31 / 1 gives 31/0. 0 / 3 gives 0/0. 2 / 3 gives 0/2. All with latency 6 cycles from the start edge.
- 5 / 0: done one cycle after the start edge, quotient=31, remainder=0, div_by_zero=1. A following 6/3 clears div_by_zero and gives 2/0.
- start re-pulsed with 9/2 during RUN of 21/3: ignored, result 7/0. Then start held high with 9/2 and 30/3: done pulses 6 cycles apart with 4/1 then 10/0.
- rst raised for one cycle at the third RUN cycle of 27/3:
  - all outputs 0 immediately, asynchronous to clk, with no done pulse.
  - a new start of 27/3 then gives 9/0 normally.
- Exhaustive round trip with the multiplier, divisor 1..3 and multiplier operand 0..7:
  - feed p = m*q into seq_divider as dividend, m as divisor, then check quotient=q and remainder=0.
  - also check dividend = divisor*quotient + remainder and remainder < divisor for all dividend 0..31, divisor 1..3.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider that pairs with the 2x3 multiplier.
// Produces one quotient bit per clock, MSB first, behind a start/busy/done
// handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        division request, sampled in IDLE or DONE only
//   dividend     DW-bit numerator, latched on an accepted start
//   divisor      VW-bit denominator, latched on an accepted start
//   busy         high exactly while a division is iterating (RUN)
//   done         one-cycle pulse when results become valid (DONE)
//   quotient     DW-bit result, held until the next accepted start
//   remainder    VW-bit result, held until the next accepted start
//   div_by_zero  set with done when the divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int unsigned DW = 5,
  parameter int unsigned VW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  // Partial remainder carries one guard bit above the divisor width.
  localparam int unsigned PW = VW + 1;
  // Iteration counter wide enough to hold DW.
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;

  logic [DW-1:0] dvd_q, dvd_d;   // dividend shifts out MSB, quotient shifts in LSB
  logic [VW-1:0] dvs_q, dvs_d;   // latched divisor
  logic [PW-1:0] pr_q,  pr_d;    // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;   // completed restoring steps
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic          accept;
  logic          zero_div;
  logic          last_step;
  logic [PW-1:0] pr_shift;
  logic          q_bit;
  logic [PW-1:0] step_pr;
  logic [DW-1:0] step_dvd;

  // Handshake decode: a start is honoured whenever no division is iterating.
  assign accept    = start && (state_q != S_RUN);
  assign zero_div  = (divisor == '0);
  assign last_step = (cnt_q == CW'(DW - 1));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The guard bit of pr_q is always zero after a step, so truncation is safe.
  always_comb begin
    pr_shift = PW'({pr_q, dvd_q[DW-1]});
    q_bit    = (pr_shift >= {1'b0, dvs_q});
    step_pr  = q_bit ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
    step_dvd = {dvd_q[DW-2:0], q_bit};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = zero_div ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // Datapath next-state: load on accept, iterate in RUN, publish on last step.
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    pr_d  = pr_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;

    if (accept) begin
      dvd_d = dividend;
      dvs_d = divisor;
      pr_d  = '0;
      cnt_d = '0;
      quo_d = '0;
      rem_d = '0;
      dbz_d = 1'b0;
      // Zero divisor skips iteration and reports the saturated quotient.
      if (zero_div) begin
        quo_d = '1;
        dbz_d = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      dvd_d = step_dvd;
      pr_d  = step_pr;
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        quo_d = step_dvd;
        rem_d = step_pr[VW-1:0];
      end
    end
  end

  // Datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      pr_q  <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      pr_q  <= pr_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int unsigned DW = 5;
  localparam int unsigned VW = 2;
  localparam int MAX_WAIT = 20;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int n_checks;
  int n_errors;
  int cyc;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulse start for one cycle and wait (bounded) for done.
  // lat counts cycles from the start edge to the edge that raised done.
  task automatic exec(input int a, input int b, output int lat, output int bcnt);
    dividend = DW'(a);
    divisor  = VW'(b);
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!done && lat < MAX_WAIT) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic directed(input string tag, input int a, input int b,
                          input int eq, input int er, input int ez, input int elat);
    int lat;
    int bcnt;
    exec(a, b, lat, bcnt);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(elat - 1));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int c1;
    int c2;
    bit seen;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    // Basic division plus hold of results after done.
    directed("d21_3", 21, 3, 7, 0, 0, 6);
    for (int i = 0; i < 10; i++) tick();
    check("hold_quotient", 32'(quotient), 32'd7);
    check("hold_remainder", 32'(remainder), 32'd0);
    check("hold_done", 32'(done), 32'd0);

    directed("d23_2", 23, 2, 11, 1, 0, 6);
    directed("d31_1", 31, 1, 31, 0, 0, 6);
    directed("d0_3", 0, 3, 0, 0, 0, 6);
    directed("d2_3", 2, 3, 0, 2, 0, 6);

    // Divide by zero, then a normal division clears the flag.
    directed("d5_0", 5, 0, 31, 0, 1, 1);
    directed("d6_3", 6, 3, 2, 0, 0, 6);

    // start re-pulsed with new operands during RUN is ignored.
    dividend = 5'd21;
    divisor  = 2'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 5'd9;
    divisor  = 2'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (!done && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    check("ignore_latency", 32'(lat), 32'd6);
    check("ignore_quotient", 32'(quotient), 32'd7);
    check("ignore_remainder", 32'(remainder), 32'd0);
    tick();

    // Back-to-back with start held high: 9/2 then 30/3, six cycles apart.
    dividend = 5'd9;
    divisor  = 2'd2;
    start    = 1'b1;
    tick();
    lat = 1;
    while (!done && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    c1 = cyc;
    check("b2b_first_latency", 32'(lat), 32'd6);
    check("b2b_first_quotient", 32'(quotient), 32'd4);
    check("b2b_first_remainder", 32'(remainder), 32'd1);
    check("b2b_busy_in_done", 32'(busy), 32'd0);
    dividend = 5'd30;
    divisor  = 2'd3;
    tick();
    check("b2b_rerun_busy", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    c2 = cyc;
    start = 1'b0;
    check("b2b_gap", 32'(c2 - c1), 32'd6);
    check("b2b_second_quotient", 32'(quotient), 32'd10);
    check("b2b_second_remainder", 32'(remainder), 32'd0);
    tick();
    check("b2b_idle_done", 32'(done), 32'd0);

    // Reset in the third RUN cycle of 27/3 discards the division at once.
    dividend = 5'd27;
    divisor  = 2'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quotient", 32'(quotient), 32'd0);
    check("arst_remainder", 32'(remainder), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    check("arst_no_done", 32'(seen), 32'd0);
    directed("d27_3", 27, 3, 9, 0, 0, 6);

    // Round trip against the multiplier: p = m*q divided by m returns q, 0.
    for (int m = 1; m <= 3; m++) begin
      for (int q = 0; q <= 7; q++) begin
        exec(m * q, m, lat, bcnt);
        check("rt_mul_latency", 32'(lat), 32'd6);
        check("rt_mul_quotient", 32'(quotient), 32'(q));
        check("rt_mul_remainder", 32'(remainder), 32'd0);
      end
    end

    // Identity dividend = divisor*quotient + remainder with remainder < divisor.
    for (int b = 1; b <= 3; b++) begin
      for (int a = 0; a <= 31; a++) begin
        exec(a, b, lat, bcnt);
        check("rt_sum", 32'(b * int'(quotient) + int'(remainder)), 32'(a));
        check("rt_rem_lt", 32'(int'(remainder) < b), 32'd1);
        check("rt_dbz", 32'(div_by_zero), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
